// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used by slaves in the harness.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HWORD   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/imem_resp_pkg.sv
// Types and helpers private to the instruction/data memory responder.
package imem_resp_pkg;

    import ahb3lite_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR1,
        ERR2
    } state_t;

    // Attributes of the accepted transfer carried into its data phase.
    typedef struct packed {
        logic            write;
        logic [BE_W-1:0] be;
    } dphase_t;

    // Byte-lane enables for a legal (aligned, size<=word) transfer.
    function automatic logic [BE_W-1:0] be_gen(input logic [2:0] size, input logic [1:0] addr);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            HSIZE_BYTE:  be = 4'b0001 << addr;
            HSIZE_HWORD: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD:  be = 4'b1111;
            default:     be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb3lite_imem_responder_if.sv
// AHB3-Lite signal bundle between the initiator side and the memory responder.
interface ahb3lite_imem_responder_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb3lite_imem_array.sv
// DEPTH x 32 word storage with per-byte write enables and asynchronous read.
// Contents come up as INIT_VALUE and are never touched by reset.
module ahb3lite_imem_array #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0013,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH] = '{default: INIT_VALUE};

    // Byte-lane write of the addressed word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb3lite_imem_responder.sv
// AHB3-Lite memory responder for the RV12 fetch/load/store harness.
// Zero-wait data phases by default; define WAIT_STATES_EN to stretch each
// data phase by wait_cycles_i cycles sampled at accept. Illegal transfers
// (bad size, misaligned, out of range) get the two-cycle ERROR response.
module ahb3lite_imem_responder
    import ahb3lite_pkg::*;
    import imem_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] wait_cycles_i,
    ahb3lite_imem_responder_if.slave ahb
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dphase_t          dp_q, dp_d;
    logic [AW-1:0]    idx_q;
    logic             active_q;
    logic [31:0]      rdata_q;

    logic [31:0]      off_c;
    logic             misalign_c;
    logic             legal_c;
    logic             acc_c;
    logic [CNT_W-1:0] n_c;
    logic             done_c;
    logic             we_c;
    logic             rd_done_c;
    logic [31:0]      arr_rdata_c;
    logic             hreadyout_c;
    logic             hresp_c;
    logic             unused_c;

    // Address-phase decode: offset, alignment and legality of the offered transfer.
    assign off_c = ahb.HADDR - BASE_ADDR;

    // Alignment check against the transfer size.
    always_comb begin
        misalign_c = 1'b0;
        case (ahb.HSIZE)
            HSIZE_HWORD: misalign_c = ahb.HADDR[0];
            HSIZE_WORD:  misalign_c = |ahb.HADDR[1:0];
            default:     misalign_c = 1'b0;
        endcase
    end

    assign legal_c = (ahb.HSIZE <= HSIZE_WORD) && !misalign_c && !(|off_c[31:AW+2]);
    assign acc_c   = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1];

`ifdef WAIT_STATES_EN
    assign n_c      = wait_cycles_i;
    assign unused_c = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0], off_c[1:0]};
`else
    assign n_c      = '0;
    assign unused_c = ^{ahb.HBURST, ahb.HPROT, ahb.HMASTLOCK, ahb.HTRANS[0], off_c[1:0],
                        wait_cycles_i};
`endif

    // FSM state and wait counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and response decode; a new transfer can start in IDLE or ERR2.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hreadyout_c = 1'b1;
        hresp_c     = HRESP_OKAY;
        case (state_q)
            IDLE, ERR2: begin
                hresp_c = (state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
                state_d = IDLE;
                if (acc_c) begin
                    if (!legal_c) begin
                        state_d = ERR1;
                    end else if (n_c != '0) begin
                        state_d = WAIT;
                        cnt_d   = n_c;
                    end
                end
            end
            WAIT: begin
                hreadyout_c = 1'b0;
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            ERR1: begin
                hreadyout_c = 1'b0;
                hresp_c     = HRESP_ERROR;
                state_d     = ERR2;
            end
            default: state_d = IDLE;
        endcase
    end

    // Attributes latched for the data phase.
    always_comb begin
        dp_d       = dp_q;
        dp_d.write = ahb.HWRITE;
        dp_d.be    = be_gen(ahb.HSIZE, ahb.HADDR[1:0]);
    end

    // Data-phase bookkeeping; held while the bus is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_q     <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (ahb.HREADY) begin
            active_q <= acc_c && legal_c;
            if (acc_c) begin
                dp_q  <= dp_d;
                idx_q <= off_c[AW+1:2];
            end
        end
    end

    // A legal data phase completes on the first IDLE cycle after its accept.
    assign done_c    = active_q && (state_q == IDLE);
    assign we_c      = done_c && dp_q.write && !rst;
    assign rd_done_c = done_c && !dp_q.write;

    ahb3lite_imem_array #(
        .DEPTH      (DEPTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_array (
        .clk     (clk),
        .we_i    (we_c),
        .be_i    (dp_q.be),
        .idx_i   (idx_q),
        .wdata_i (ahb.HWDATA),
        .rdata_o (arr_rdata_c)
    );

    // Read data holder so HRDATA keeps the last completed read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_done_c) begin
            rdata_q <= arr_rdata_c;
        end
    end

    assign ahb.HRDATA    = rd_done_c ? arr_rdata_c : rdata_q;
    assign ahb.HREADYOUT = hreadyout_c;
    assign ahb.HRESP     = hresp_c;

endmodule
